// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared pipeline definitions for the decode-stage scoreboard:
//   - architectural register count and register index type
//   - the hardwired-zero register index
//   - a helper that tells whether an index names a trackable register
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int NREG = 32;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  // Register 0 never holds a pending write and never causes a hazard.
  function automatic logic is_tracked(input reg_idx_t idx);
    return idx != REG_ZERO;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// -----------------------------------------------------------------------------
// sb_counter
//   Pending-write counter for one architectural register.
//   Ports:
//     i_clk     pipeline clock, rising edge
//     i_reset   synchronous, active-high; clears the count
//     i_inc     an issued instruction allocates this register
//     i_dec     the WB instruction retires a write to this register
//     o_cnt     current pending count
//     o_at_max  count is at its ceiling (2**CNT_W-1)
//     o_nz      count is non-zero
//   Simultaneous inc and dec leave the count unchanged. A dec at zero holds
//   at zero rather than wrapping.
// -----------------------------------------------------------------------------
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_at_max,
  output logic             o_nz
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of evaluation order across blocks.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else begin
      case ({i_inc, i_dec})
        2'b10: if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        2'b01: if (r_cnt != '0)      r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_cnt    = r_cnt;
  assign o_at_max = (r_cnt == CNT_MAX);
  assign o_nz     = (r_cnt != '0);

  // A retire for a register with nothing in flight means WB and ID disagree.
  a_no_underflow: assert property (@(posedge i_clk) disable iff (i_reset)
    i_dec |-> (r_cnt != '0));

endmodule

// File: rtl/id_scoreboard_ctrl.sv
// -----------------------------------------------------------------------------
// id_scoreboard_ctrl
//   Register scoreboard and issue controller for the decode stage. Counts
//   in-flight writes per architectural register between ID issue and WB
//   retire, stalls IF/ID while a source operand is pending, and bubbles ID/EX.
//   Ports:
//     i_clk          pipeline clock, rising edge
//     i_reset        synchronous, active-high
//     i_id_valid     IF/ID holds a real instruction
//     i_id_rs/rt     source register indices
//     i_id_use_rs/rt instruction reads rs / rt
//     i_id_dest      destination register (after RegDst)
//     i_id_reg_write RegWrite of the decoding instruction
//     i_id_kill      squash the ID instruction this cycle
//     i_wb_reg_write RegWrite at WB
//     i_wb_writereg  MEM/WB write register
//     o_stall        hold PC and IF/ID (combinational)
//     o_id_issue     load ID/EX; otherwise insert a bubble
//     o_busy_vec     bit r set while register r has a pending write
//     o_perf_stalls  saturating stall-cycle count
// -----------------------------------------------------------------------------
module id_scoreboard_ctrl #(
  parameter int NREG      = pipe_pkg::NREG,
  parameter int CNT_W     = 2,
  parameter bit WB_BYPASS = 1'b1,
  parameter int PERF_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_id_valid,
  input  logic [4:0]        i_id_rs,
  input  logic [4:0]        i_id_rt,
  input  logic              i_id_use_rs,
  input  logic              i_id_use_rt,
  input  logic [4:0]        i_id_dest,
  input  logic              i_id_reg_write,
  input  logic              i_id_kill,
  input  logic              i_wb_reg_write,
  input  logic [4:0]        i_wb_writereg,
  output logic              o_stall,
  output logic              o_id_issue,
  output logic [NREG-1:0]   o_busy_vec,
  output logic [PERF_W-1:0] o_perf_stalls
);

  import pipe_pkg::*;

  logic [CNT_W-1:0]  w_cnt [NREG];
  logic [NREG-1:0]   w_at_max;
  logic [NREG-1:0]   w_nz;
  logic [NREG-1:0]   w_inc;
  logic [NREG-1:0]   w_dec;

  logic              w_rel;
  logic              w_hz_rs;
  logic              w_hz_rt;
  logic              w_full;
  logic              w_stall;
  logic              w_issue;
  logic              w_alloc;
  logic [CNT_W-1:0]  w_pend_rs;
  logic [CNT_W-1:0]  w_pend_rt;

  logic [PERF_W-1:0] r_perf_stalls;

  // Register 0 is hardwired zero: no counter, always idle.
  assign w_cnt[0]    = '0;
  assign w_at_max[0] = 1'b0;
  assign w_nz[0]     = 1'b0;
  assign w_inc[0]    = 1'b0;
  assign w_dec[0]    = 1'b0;

  genvar g;
  generate
    for (g = 1; g < NREG; g++) begin : g_cnt
      assign w_inc[g] = w_alloc && (i_id_dest == reg_idx_t'(g));
      assign w_dec[g] = w_rel   && (i_wb_writereg == reg_idx_t'(g));

      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_inc    (w_inc[g]),
        .i_dec    (w_dec[g]),
        .o_cnt    (w_cnt[g]),
        .o_at_max (w_at_max[g]),
        .o_nz     (w_nz[g])
      );
    end
  endgenerate

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_rel     = 1'b0;
    w_pend_rs = '0;
    w_pend_rt = '0;
    w_hz_rs   = 1'b0;
    w_hz_rt   = 1'b0;
    w_full    = 1'b0;
    w_stall   = 1'b0;
    w_issue   = 1'b0;
    w_alloc   = 1'b0;

    w_rel = i_wb_reg_write && is_tracked(i_wb_writereg);

    // With a write-first regfile the retiring write is already readable, so
    // its own count entry no longer blocks a consumer this cycle.
    w_pend_rs = w_cnt[i_id_rs] -
                CNT_W'(WB_BYPASS && w_rel && (i_wb_writereg == i_id_rs));
    w_pend_rt = w_cnt[i_id_rt] -
                CNT_W'(WB_BYPASS && w_rel && (i_wb_writereg == i_id_rt));

    w_hz_rs = i_id_use_rs && is_tracked(i_id_rs) && (w_pend_rs != '0);
    w_hz_rt = i_id_use_rt && is_tracked(i_id_rt) && (w_pend_rt != '0);

    // A retire to the same register this cycle frees a slot for the writer.
    w_full = i_id_reg_write && is_tracked(i_id_dest) && w_at_max[i_id_dest] &&
             !(w_rel && (i_wb_writereg == i_id_dest));

    w_stall = !i_reset && i_id_valid && !i_id_kill && (w_hz_rs || w_hz_rt || w_full);
    w_issue = !i_reset && i_id_valid && !i_id_kill && !w_stall;
    w_alloc = w_issue && i_id_reg_write && is_tracked(i_id_dest);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_perf_stalls <= '0;
    end else if (w_stall && (r_perf_stalls != '1)) begin
      r_perf_stalls <= r_perf_stalls + 1'b1;
    end
  end

  assign o_stall       = w_stall;
  assign o_id_issue    = w_issue;
  assign o_busy_vec    = w_nz;
  assign o_perf_stalls = r_perf_stalls;

endmodule
